// File: rtl/fifo_rd_arbiter_if.sv
// Bus bundle between the read-side arbiter, its input FIFOs and the downstream byte sink.
// The master modport is the arbiter's view; the slave modport is the FIFO/sink side.
interface fifo_rd_arbiter_if #(
    parameter int NPORTS    = 4,
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4,
    parameter int PORT_W    = (NPORTS > 1) ? $clog2(NPORTS) : 1
);
    logic [NPORTS-1:0]        rempty;
    logic [NPORTS*UWIDTH-1:0] rdata_all;
    logic [NPORTS-1:0]        port_en;
    logic                     out_ready;
    logic [NPORTS-1:0]        rinc;
    logic [PTR_IN_SZ-1:0]     raddr_in;
    logic [UWIDTH-1:0]        out_data;
    logic                     out_valid;
    logic                     out_sop;
    logic                     out_eop;
    logic [PORT_W-1:0]        out_port;
    logic [15:0]              pkt_cnt;

    modport master (
        input  rempty, rdata_all, port_en, out_ready,
        output rinc, raddr_in, out_data, out_valid, out_sop, out_eop, out_port, pkt_cnt
    );

    modport slave (
        output rempty, rdata_all, port_en, out_ready,
        input  rinc, raddr_in, out_data, out_valid, out_sop, out_eop, out_port, pkt_cnt
    );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read arbiter: streams one whole packet (WIDTH bytes) from a granted FIFO,
// then pops that FIFO and re-arbitrates.
module fifo_rd_arbiter #(
    parameter int          NPORTS      = 4,
    parameter int          WIDTH       = 11,
    parameter int          UWIDTH      = 8,
    parameter int          PTR_IN_SZ   = 4,
    parameter logic [15:0] PKT_CNT_RST = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    fifo_rd_arbiter_if.master  bus
);
    localparam int PORT_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [PTR_IN_SZ-1:0] LAST_IDX = PTR_IN_SZ'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        POP  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_IN_SZ-1:0] idx_q, idx_d;
    logic [PORT_W-1:0]    grant_q, grant_d;
    logic [PORT_W-1:0]    last_q, last_d;
    logic [15:0]          pkt_q, pkt_d;
    logic [NPORTS-1:0]    cand;

    // Nearest candidate after 'last' wins; 'last' itself is reached only at distance NPORTS.
    function automatic logic [PORT_W-1:0] rr_pick(input logic [NPORTS-1:0] req,
                                                  input logic [PORT_W-1:0] last);
        logic [PORT_W-1:0] pick;
        pick = last;
        for (int k = NPORTS; k >= 1; k--) begin
            for (int j = 0; j < NPORTS; j++) begin
                if (((int'(last) + k) % NPORTS) == j && req[j]) begin
                    pick = PORT_W'(j);
                end
            end
        end
        return pick;
    endfunction

    assign cand = ~bus.rempty & bus.port_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            grant_q <= '0;
            last_q  <= PORT_W'(NPORTS - 1);
            pkt_q   <= PKT_CNT_RST;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pkt_q   <= pkt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        last_d  = last_q;
        pkt_d   = pkt_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    grant_d = rr_pick(cand, last_q);
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Grant is locked for the whole packet; enables and empties are ignored here.
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = POP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            POP: begin
                last_d  = grant_q;
                pkt_d   = pkt_q + 16'd1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Strobes are also gated by rst so nothing leaks out while reset is held.
    always_comb begin
        bus.rinc      = '0;
        bus.out_valid = 1'b0;
        bus.out_sop   = 1'b0;
        bus.out_eop   = 1'b0;
        bus.raddr_in  = '0;
        if (rst) begin
            if (state_q == SEND) begin
                bus.out_valid = 1'b1;
                bus.raddr_in  = idx_q;
                bus.out_sop   = (idx_q == '0);
                bus.out_eop   = (idx_q == LAST_IDX);
            end
            if (state_q == POP) begin
                for (int i = 0; i < NPORTS; i++) begin
                    bus.rinc[i] = (grant_q == PORT_W'(i));
                end
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (grant_q == PORT_W'(i)) begin
                bus.out_data = bus.rdata_all[i*UWIDTH +: UWIDTH];
            end
        end
    end

    assign bus.out_port = grant_q;
    assign bus.pkt_cnt  = pkt_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: a 4-port instance fed by modelled FIFOs, plus a
// 2-port, 2-byte instance whose packet counter starts near its wrap point.
module tb_fifo_rd_arbiter;
    localparam int NP = 4;
    localparam int W  = 11;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    fifo_rd_arbiter_if #(.NPORTS(NP), .UWIDTH(8), .PTR_IN_SZ(4)) ifc ();
    fifo_rd_arbiter_if #(.NPORTS(2),  .UWIDTH(8), .PTR_IN_SZ(4)) ifc2 ();

    fifo_rd_arbiter #(.NPORTS(NP), .WIDTH(W), .UWIDTH(8), .PTR_IN_SZ(4)) dut (
        .clk(clk), .rst(rst), .bus(ifc.master)
    );

    fifo_rd_arbiter #(.NPORTS(2), .WIDTH(2), .UWIDTH(8), .PTR_IN_SZ(4),
                      .PKT_CNT_RST(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst2), .bus(ifc2.master)
    );

    assign ifc2.rempty    = 2'b10;
    assign ifc2.port_en   = 2'b11;
    assign ifc2.out_ready = 1'b1;
    assign ifc2.rdata_all = 16'h0000;

    int cnt[NP];
    int popped[NP];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int acc = 0;
    int exp_pkt = 0;

    function automatic logic [7:0] byte_of(input int port, input int pc, input logic [3:0] a);
        logic [1:0] p2;
        logic [1:0] c2;
        p2 = 2'(port);
        c2 = 2'(pc);
        return {p2, c2, a};
    endfunction

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            ifc.rempty[i] = (cnt[i] == 0);
            ifc.rdata_all[i*8 +: 8] = byte_of(i, popped[i], ifc.raddr_in);
        end
    end

    function automatic logic [16:0] bundle();
        return {ifc.out_valid, ifc.out_sop, ifc.out_eop, ifc.out_port, ifc.raddr_in, ifc.out_data};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: count an accepted byte, advance to the next falling edge, apply FIFO pops.
    task automatic cyc();
        if (ifc.out_valid && ifc.out_ready) acc++;
        @(negedge clk);
        cyc_n++;
        for (int i = 0; i < NP; i++) begin
            if (ifc.rinc[i] && cnt[i] > 0) begin
                cnt[i]--;
                popped[i]++;
            end
        end
    endtask

    // Called on the falling edge showing byte 0. act: 0 plain, 1 stall at byte 4,
    // 2 drop port_en[1] at byte 3, 3 assert reset at byte 5.
    task automatic run_pkt(input int port, input int act);
        logic [16:0] e;
        logic [3:0]  onehot;
        bit aborted;
        aborted = 1'b0;
        acc = 0;
        for (int k = 0; k < W && !aborted; k++) begin
            e = {1'b1, (k == 0), (k == W - 1), 2'(port), 4'(k), byte_of(port, popped[port], 4'(k))};
            chk($sformatf("p%0d_byte%0d", port, k), bundle(), e);
            if (act == 1 && k == 4) begin
                ifc.out_ready = 1'b0;
                repeat (2) begin
                    cyc();
                    chk($sformatf("p%0d_hold%0d", port, k), bundle(), e);
                end
                ifc.out_ready = 1'b1;
            end
            if (act == 2 && k == 3) ifc.port_en[1] = 1'b0;
            if (act == 3 && k == 5) begin
                rst = 1'b0;
                cyc();
                chk("rst_mid_out", {ifc.out_valid, ifc.out_sop, ifc.out_eop, ifc.rinc, ifc.raddr_in}, 0);
                chk("rst_mid_port", ifc.out_port, 0);
                chk("rst_mid_cnt", ifc.pkt_cnt, 0);
                aborted = 1'b1;
            end else begin
                cyc();
            end
        end
        if (!aborted) begin
            onehot = 4'b0001 << port;
            chk($sformatf("p%0d_pop", port), {ifc.out_valid, ifc.raddr_in, ifc.rinc}, {1'b0, 4'h0, onehot});
            exp_pkt++;
            cyc();
            chk($sformatf("p%0d_pkt_cnt", port), ifc.pkt_cnt, exp_pkt);
            if (act == 1) chk("accepted_bytes", acc, W);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int prev;
        int t;
        logic [15:0] wrap_exp[3];
        wrap_exp[0] = 16'hFFFF;
        wrap_exp[1] = 16'h0000;
        wrap_exp[2] = 16'h0001;
        prev = 0;

        rst = 1'b0;
        rst2 = 1'b0;
        ifc.port_en = 4'hF;
        ifc.out_ready = 1'b1;
        for (int i = 0; i < NP; i++) begin
            cnt[i] = 0;
            popped[i] = 0;
        end
        repeat (3) cyc();
        chk("rst_out", {ifc.out_valid, ifc.out_sop, ifc.out_eop, ifc.rinc, ifc.raddr_in}, 0);
        chk("rst_port", ifc.out_port, 0);
        chk("rst_pkt_cnt", ifc.pkt_cnt, 0);
        chk("rst2_pkt_cnt", ifc2.pkt_cnt, 16'hFFFE);
        rst = 1'b1;
        repeat (3) cyc();
        chk("idle_none", {ifc.out_valid, ifc.rinc, ifc.raddr_in}, 0);

        // single packet from port 0, one-cycle request-to-valid latency
        cnt[0] = 1;
        cyc();
        run_pkt(0, 0);
        chk("empty_after_pop", ifc.rempty, 4'hF);
        cyc();
        chk("idle_after_pkt", ifc.out_valid, 0);

        // sole candidate equal to last grant is granted again
        cnt[0] = 1;
        cyc();
        run_pkt(0, 0);

        // round robin over all four, fixed 13-cycle packet spacing
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        exp_pkt = 0;
        for (int i = 0; i < NP; i++) cnt[i] = 2;
        cyc();
        for (int p = 0; p < 8; p++) begin
            st = cyc_n;
            if (p > 0) chk("pkt_spacing", st - prev, 13);
            prev = st;
            run_pkt(p % NP, 0);
            if (p < 7) cyc();
        end
        cyc();
        chk("idle_after_rr", {ifc.out_valid, ifc.rempty}, {1'b0, 4'hF});

        // backpressure mid-packet
        cnt[1] = 1;
        cyc();
        run_pkt(1, 1);

        // port 2 masked; port 1 enable dropped during its own transfer
        ifc.port_en = 4'b1011;
        for (int i = 0; i < NP; i++) cnt[i] = 1;
        cyc();
        run_pkt(3, 0);
        cyc();
        run_pkt(0, 0);
        cyc();
        run_pkt(1, 2);
        repeat (3) cyc();
        chk("port2_blocked", {ifc.out_valid, ifc.rinc}, 0);
        ifc.port_en = 4'hF;
        cyc();
        run_pkt(2, 0);

        // reset in the middle of a port-3 packet; port 3 resent in full afterwards
        cnt[3] = 1;
        cyc();
        run_pkt(3, 3);
        rst = 1'b1;
        exp_pkt = 0;
        cnt[0] = 1;
        cyc();
        run_pkt(0, 0);
        cyc();
        run_pkt(3, 0);

        // packet counter wrap on the second instance
        rst2 = 1'b1;
        for (int n = 0; n < 3; n++) begin
            t = 0;
            while (ifc2.rinc == 2'b00 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("wrap_pop_seen", (t < 20), 1);
            @(negedge clk);
            chk($sformatf("wrap_cnt%0d", n), ifc2.pkt_cnt, wrap_exp[n]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
